// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads instruction memory combinationally and
// buffers {pc, instr} pairs in a 2-entry queue drained by decode via valid/ready.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        fault,
   output logic [1:0]  fault_cause
);

   typedef enum logic {RUN, HALT} state_t;

   localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
   localparam logic [1:0] CAUSE_RANGE      = 2'b10;

   state_t      state, state_next;
   logic [31:0] pc;
   logic [1:0]  count;
   logic [31:0] tail_instr, tail_pc;
   logic        in_range, misaligned;
   logic        pop, push, set_fault;
   logic [1:0]  new_cause;

   assign imem_addr  = pc;
   assign if_valid   = (count != 2'd0);
   assign in_range   = ({2'b00, pc[31:2]} < 32'(IMEM_WORDS));
   assign misaligned = (redirect_pc[1:0] != 2'b00);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_next;
   end

   // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      if (state == RUN) begin
         if (redirect_valid) begin
            if (misaligned) state_next = HALT;
         end else if (!in_range) begin
            state_next = HALT;
         end
      end
   end

   always_comb begin
      pop       = if_valid & if_ready & ~redirect_valid;
      push      = 1'b0;
      set_fault = 1'b0;
      new_cause = 2'b00;
      if (state == RUN) begin
         if (redirect_valid) begin
            if (misaligned) begin
               set_fault = 1'b1;
               new_cause = CAUSE_MISALIGNED;
            end
         end else if (!in_range) begin
            set_fault = 1'b1;
            new_cause = CAUSE_RANGE;
         end else begin
            push = (count != 2'd2) | pop;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (state == RUN && redirect_valid && !misaligned) begin
         pc <= redirect_pc;
      end else if (push) begin
         pc <= pc + 32'd4;
      end
   end

   // Cause is captured only on the first fault; later events cannot overwrite it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault       <= 1'b0;
         fault_cause <= 2'b00;
      end else if (set_fault && !fault) begin
         fault       <= 1'b1;
         fault_cause <= new_cause;
      end
   end

   // Head entry doubles as the output register pair.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= 2'd0;
         if_instr <= 32'h0;
         if_pc    <= 32'h0;
      end else if (redirect_valid) begin
         count <= 2'd0;
      end else begin
         case (count)
            2'd0: begin
               if (push) begin
                  if_instr <= imem_data;
                  if_pc    <= pc;
                  count    <= 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  if_instr <= imem_data;
                  if_pc    <= pc;
               end else if (push) begin
                  count <= 2'd2;
               end else if (pop) begin
                  count <= 2'd0;
               end
            end
            default: begin
               if (pop) begin
                  if_instr <= tail_instr;
                  if_pc    <= tail_pc;
                  if (!push) count <= 2'd1;
               end
            end
         endcase
      end
   end

   // NOTE: the tail entry is pure storage guarded by count, so it carries no reset.
   always_ff @(posedge clk) begin
      if (!redirect_valid && push && ((count == 2'd1 && !pop) || count == 2'd2)) begin
         tail_instr <= imem_data;
         tail_pc    <= pc;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one DUT with the default memory size, one with 4 words
// to exercise the out-of-range fault.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          tests = 0;
   int          fails = 0;

   logic [31:0] imem_addr, imem_data, redirect_pc, if_instr, if_pc;
   logic        redirect_valid, if_valid, if_ready, fault;
   logic [1:0]  fault_cause;

   logic [31:0] o_imem_addr, o_imem_data, o_redirect_pc, o_if_instr, o_if_pc;
   logic        o_redirect_valid, o_if_valid, o_if_ready, o_fault;
   logic [1:0]  o_fault_cause;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [29:0] idx);
      case (idx)
         30'd0:   mem_word = 32'h0050_0213;
         30'd1:   mem_word = 32'h00a0_0293;
         30'd2:   mem_word = 32'h0020_8a63;
         30'd3:   mem_word = 32'h0010_0313;
         default: mem_word = 32'hA000_0000 | {2'b00, idx};
      endcase
   endfunction

   assign imem_data   = mem_word(imem_addr[31:2]);
   assign o_imem_data = mem_word(o_imem_addr[31:2]);

   fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(256)) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
      .fault(fault), .fault_cause(fault_cause)
   );

   fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(4)) dut_oor (
      .clk(clk), .rst(rst), .imem_addr(o_imem_addr), .imem_data(o_imem_data),
      .redirect_valid(o_redirect_valid), .redirect_pc(o_redirect_pc),
      .if_valid(o_if_valid), .if_ready(o_if_ready), .if_instr(o_if_instr), .if_pc(o_if_pc),
      .fault(o_fault), .fault_cause(o_fault_cause)
   );

   // Inputs change and outputs are sampled on the falling edge.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
      o_redirect_valid = 1'b0; o_redirect_pc = 32'h0; o_if_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
      o_redirect_valid = 1'b0; o_redirect_pc = 32'h0; o_if_ready = 1'b0;
      @(negedge clk);
      tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL reset if_valid: got %b want 0", if_valid); end
      tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset imem_addr: got %h want 0", imem_addr); end
      tests++; if (if_pc !== 32'h0 || if_instr !== 32'h0) begin fails++; $display("FAIL reset head: got pc %h instr %h want 0 0", if_pc, if_instr); end
      tests++; if (fault !== 1'b0 || fault_cause !== 2'b00) begin fails++; $display("FAIL reset fault: got %b/%b want 0/00", fault, fault_cause); end
      rst = 1'b0;
   endtask

   task automatic test_straight_line();
      do_reset();
      if_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_instr !== mem_word(30'(i))) begin
            fails++; $display("FAIL straight[%0d]: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                              i, if_valid, if_pc, if_instr, 32'(4 * i), mem_word(30'(i)));
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      @(negedge clk);
      tests++; if (imem_addr !== 32'h4) begin fails++; $display("FAIL bp pc after 1: got %h want 4", imem_addr); end
      @(negedge clk);
      tests++; if (imem_addr !== 32'h8) begin fails++; $display("FAIL bp pc after 2: got %h want 8", imem_addr); end
      @(negedge clk);
      tests++; if (imem_addr !== 32'h8) begin fails++; $display("FAIL bp pc frozen: got %h want 8", imem_addr); end
      tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h0050_0213) begin
         fails++; $display("FAIL bp head held: got v=%b pc=%h instr=%h want 1 0 00500213", if_valid, if_pc, if_instr);
      end
      if_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         tests++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_instr !== mem_word(30'(i))) begin
            fails++; $display("FAIL bp drain[%0d]: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                              i, if_valid, if_pc, if_instr, 32'(4 * i), mem_word(30'(i)));
         end
      end
   endtask

   task automatic test_redirect_full();
      do_reset();
      repeat (2) @(negedge clk);
      tests++; if (imem_addr !== 32'h8 || if_pc !== 32'h0) begin fails++; $display("FAIL redir setup: got pc=%h head=%h want 8 0", imem_addr, if_pc); end
      if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h2C;
      @(negedge clk);
      redirect_valid = 1'b0;
      tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL redir flush: got if_valid %b want 0", if_valid); end
      tests++; if (imem_addr !== 32'h2C) begin fails++; $display("FAIL redir pc: got %h want 0000002c", imem_addr); end
      @(negedge clk);
      tests++; if (if_valid !== 1'b1 || if_pc !== 32'h2C || if_instr !== 32'hA000_000B) begin
         fails++; $display("FAIL redir target: got v=%b pc=%h instr=%h want 1 0000002c a000000b", if_valid, if_pc, if_instr);
      end
      @(negedge clk);
      tests++; if (if_pc !== 32'h30 || if_instr !== 32'hA000_000C) begin
         fails++; $display("FAIL redir next: got pc=%h instr=%h want 00000030 a000000c", if_pc, if_instr);
      end
   endtask

   task automatic test_misaligned();
      do_reset();
      if_ready = 1'b1;
      repeat (2) @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h22;
      @(negedge clk);
      redirect_valid = 1'b0;
      tests++; if (fault !== 1'b1 || fault_cause !== 2'b01) begin fails++; $display("FAIL misaligned fault: got %b/%b want 1/01", fault, fault_cause); end
      tests++; if (imem_addr !== 32'h8 || if_valid !== 1'b0) begin fails++; $display("FAIL misaligned pc: got pc=%h v=%b want 8 0", imem_addr, if_valid); end
      @(negedge clk);
      tests++; if (imem_addr !== 32'h8 || if_valid !== 1'b0) begin fails++; $display("FAIL halt no push: got pc=%h v=%b want 8 0", imem_addr, if_valid); end
      redirect_valid = 1'b1; redirect_pc = 32'h10;
      @(negedge clk);
      redirect_valid = 1'b0;
      @(negedge clk);
      tests++; if (imem_addr !== 32'h8 || if_valid !== 1'b0) begin fails++; $display("FAIL halt redirect: got pc=%h v=%b want 8 0", imem_addr, if_valid); end
      tests++; if (fault !== 1'b1 || fault_cause !== 2'b01) begin fails++; $display("FAIL cause sticky: got %b/%b want 1/01", fault, fault_cause); end
   endtask

   task automatic test_out_of_range();
      do_reset();
      repeat (3) @(negedge clk);
      tests++; if (o_imem_addr !== 32'h8 || o_fault !== 1'b0 || o_if_pc !== 32'h0) begin
         fails++; $display("FAIL oor full: got pc=%h fault=%b head=%h want 8 0 0", o_imem_addr, o_fault, o_if_pc);
      end
      o_if_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         tests++; if (o_if_valid !== 1'b1 || o_if_pc !== 32'(4 * i) || o_if_instr !== mem_word(30'(i))) begin
            fails++; $display("FAIL oor drain[%0d]: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                              i, o_if_valid, o_if_pc, o_if_instr, 32'(4 * i), mem_word(30'(i)));
         end
      end
      tests++; if (o_fault !== 1'b1 || o_fault_cause !== 2'b10 || o_imem_addr !== 32'h10) begin
         fails++; $display("FAIL oor fault: got %b/%b pc=%h want 1/10 pc=00000010", o_fault, o_fault_cause, o_imem_addr);
      end
      @(negedge clk);
      tests++; if (o_if_valid !== 1'b0 || o_imem_addr !== 32'h10) begin fails++; $display("FAIL oor empty: got v=%b pc=%h want 0 00000010", o_if_valid, o_imem_addr); end
   endtask

   task automatic test_async_reset();
      do_reset();
      if_ready = 1'b1; o_if_ready = 1'b1;
      repeat (5) @(negedge clk);
      tests++; if (if_valid !== 1'b1 || o_fault !== 1'b1) begin fails++; $display("FAIL async setup: got v=%b fault=%b want 1 1", if_valid, o_fault); end
      #2 rst = 1'b1;
      #1;
      tests++; if (if_valid !== 1'b0 || imem_addr !== 32'h0) begin fails++; $display("FAIL async clear: got v=%b pc=%h want 0 0", if_valid, imem_addr); end
      tests++; if (o_fault !== 1'b0 || o_fault_cause !== 2'b00) begin fails++; $display("FAIL async fault: got %b/%b want 0/00", o_fault, o_fault_cause); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
      o_redirect_valid = 1'b0; o_redirect_pc = 32'h0; o_if_ready = 1'b0;
      test_reset();
      test_straight_line();
      test_backpressure();
      test_redirect_full();
      test_misaligned();
      test_out_of_range();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
